// File: rtl/fios_seq_collect.sv
// rtl/fios_seq_collect.sv - FIOS multiplier command sequencer and tagged result collector
// Starts one multiplication per command and gathers the final-pass result words into a FWFT FIFO.
module fios_seq_collect #(
  parameter int WORD_W    = 17,
  parameter int s         = 8,
  parameter int PE_NB     = s,
  parameter int TAG_W     = 4,
  parameter int RES_DEPTH = 2*s,
  parameter int TIMEOUT   = 4096
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              cmd_valid_i,
  input  logic [TAG_W-1:0]  cmd_tag_i,
  output logic              cmd_ready_o,
  output logic              core_start_o,
  input  logic              core_a_shift_i,
  input  logic              core_res_push_i,
  input  logic [WORD_W-1:0] core_res_i,
  input  logic              core_done_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [WORD_W-1:0] res_data_o,
  output logic [TAG_W-1:0]  res_tag_o,
  output logic              res_last_o,
  output logic              busy_o,
  output logic [1:0]        err_o
);

  localparam int LAST_PASS = (PE_NB >= s) ? 0 : (s - 1) / PE_NB;
  localparam int PASS_W    = $clog2(LAST_PASS + 2);
  localparam int WCNT_W    = $clog2(s + 1) + 1;
  localparam int TMO_W     = $clog2(TIMEOUT);
  localparam int PTR_W     = $clog2(RES_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int ENT_W     = WORD_W + TAG_W + 1;

  localparam logic [PASS_W-1:0] LAST_PASS_V = PASS_W'(LAST_PASS);
  localparam logic [WCNT_W-1:0] WORDS_V     = WCNT_W'(s);
  localparam logic [WCNT_W-1:0] LAST_WORD_V = WCNT_W'(s - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST_V  = TMO_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  DEPTH_V     = CNT_W'(RES_DEPTH);
  localparam logic [CNT_W-1:0]  MIN_FREE_V  = CNT_W'(s);

  typedef enum logic [1:0] {IDLE, START, RUN, FLUSH} state_t;

  state_t              state_q;
  logic                start_q;
  logic [TAG_W-1:0]    tag_q;
  logic [PASS_W-1:0]   pass_q;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [TMO_W-1:0]    tmo_q;
  logic [1:0]          err_q;

  logic [ENT_W-1:0]    mem_q [RES_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q, count_d;

  logic                word_push, fifo_full, wr_en, rd_en;
  logic [ENT_W-1:0]    head;

  // Only pushes on the final pass carry real result words; earlier passes are partial sums.
  assign word_push = (state_q == RUN) && core_res_push_i && (pass_q == LAST_PASS_V);
  assign fifo_full = (count_q == DEPTH_V);
  assign wr_en     = word_push && !fifo_full;
  assign rd_en     = res_valid_o && res_ready_i;
  assign wcnt_d    = wcnt_q + WCNT_W'(word_push);

  assign cmd_ready_o  = (state_q == IDLE) && ((DEPTH_V - count_q) >= MIN_FREE_V);
  assign core_start_o = start_q;
  assign busy_o       = (state_q != IDLE);
  assign err_o        = err_q;

  assign res_valid_o = (count_q != '0);
  assign head        = mem_q[rd_ptr_q];
  assign res_data_o  = res_valid_o ? head[WORD_W-1:0] : '0;
  assign res_tag_o   = res_valid_o ? head[WORD_W +: TAG_W] : '0;
  assign res_last_o  = res_valid_o && head[ENT_W-1];

  always_comb begin
    count_d = count_q;
    if (wr_en && !rd_en) begin
      count_d = count_q + CNT_W'(1);
    end else if (!wr_en && rd_en) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= {(wcnt_q == LAST_WORD_V), tag_q, core_res_i};
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      tag_q   <= '0;
      pass_q  <= '0;
      wcnt_q  <= '0;
      tmo_q   <= '0;
      err_q   <= '0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid_i && cmd_ready_o) begin
            tag_q   <= cmd_tag_i;
            pass_q  <= '0;
            wcnt_q  <= '0;
            tmo_q   <= '0;
            start_q <= 1'b1;
            state_q <= START;
          end
        end
        START: state_q <= RUN;
        RUN: begin
          tmo_q <= tmo_q + TMO_W'(1);
          if (core_a_shift_i && (pass_q < LAST_PASS_V)) pass_q <= pass_q + PASS_W'(1);
          if (word_push && (wcnt_q != '1)) wcnt_q <= wcnt_d;
          if (word_push && fifo_full) err_q[1] <= 1'b1;
          // The done check uses the count including a push in the same cycle.
          if (tmo_q == TMO_LAST_V) begin
            err_q[0] <= 1'b1;
            state_q  <= FLUSH;
          end else if (core_done_i) begin
            if (wcnt_d != WORDS_V) err_q[1] <= 1'b1;
            state_q <= FLUSH;
          end
        end
        FLUSH:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
